spike_rate_decoder: RTL
=======================

// Module: spike_rate_decoder
// PURPOSE
//  Receive-side companion to the tt_um_lif neuron: turns its 1-bit spike train back into numbers.
//  Counts rising-edge spike events over a fixed window -> spike rate; measures inter-spike interval (ISI).
//  Results go out over a valid/ready handshake to readout logic or the host.
// PARAMETERS
//  WINDOW_LEN  256  clock edges per counting window (>=2)
//  CNT_W       8    width of rate_out; count saturates at 2^CNT_W-1
//  ISI_W       8    width of isi_out; interval saturates at 2^ISI_W-1
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  ena        in   1      decoder enable; low = IDLE, partial window discarded
//  spike_in   in   1      spike line from neuron, synchronous to clk
//  out_ready  in   1      consumer accepts rate_out when high with out_valid
//  rate_out   out  CNT_W  spike count of last completed window
//  out_valid  out  1      rate_out valid; held until accepted
//  overrun    out  1      sticky: a window result was dropped while out_valid pending
//  isi_out    out  ISI_W  edges between the last two spike events
//  isi_valid  out  1      one-cycle pulse when isi_out updates
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, spike_prev=0, all counters 0.
//  Event: spike_in=1 sampled with spike_prev=0. spike_prev updates every edge, also in IDLE,
//   so a line already high at enable gives no event. A level held high = one event.
//  FSM, 2 states:
//   IDLE : ena=0. win_cnt, spike_cnt, isi_cnt, isi_seen cleared. Handshake regs keep their value.
//          ena sampled 1 -> COUNT. That same edge is window cycle 0 and counts its event.
//   COUNT: ena sampled 0 -> IDLE. Partial window dropped, no out_valid.
//  Window (COUNT): win_cnt steps 0..WINDOW_LEN-1.
//   On each event, spike_cnt +1, saturating at 2^CNT_W-1.
//   At edge with win_cnt==WINDOW_LEN-1:
//    - result = spike_cnt + that edge's event (saturating).
//    - win_cnt and spike_cnt restart at 0. No gap cycle.
//    - If publish allowed: rate_out<=result, out_valid<=1, visible after that edge (latency 0 cycles past window end).
//  Handshake:
//   - Accept = out_valid & out_ready at an edge -> out_valid<=0 and overrun<=0 on that edge.
//   - rate_out stable while out_valid=1 and not accepted.
//   - Publish allowed if out_valid=0, or if accept happens on the same edge. Then out_valid stays 1 with the new value; overrun not set.
//   - Window end, out_valid=1, out_ready=0: result dropped, rate_out kept, overrun<=1.
//   - out_ready with out_valid=0: ignored.
//  ISI (COUNT):
//   - isi_cnt +1 per edge, saturating at 2^ISI_W-1.
//   - On an event with isi_seen=1: isi_out<=sat(isi_cnt+1), isi_valid<=1 for one cycle.
//   - Every event: isi_cnt<=0, isi_seen<=1.
//   - First event after entering COUNT only arms isi_seen.
//   - isi_out holds its last value in IDLE. isi_valid=0 in IDLE.
//   - ISI keeps running across window boundaries.
//  Async reset mid-window: everything reset at once, pending result and overrun lost.
// TESTING (bench: WINDOW_LEN=16, CNT_W=8, ISI_W=8 unless noted)
//  1 rst_n low mid-stream -> all outputs 0 at once; after release, ena=1 -> first out_valid after window-cycle-15 edge.
//  2 ena=1, spike_in 1-cycle pulse every 4 edges, ready=1 -> rate_out=4 per window, out_valid 1 cycle; isi_out=4, isi_valid from the 2nd pulse on.
//  3 spike_in held 1 for whole window (low before ena) -> rate_out=1, no isi_valid.
//  4 pulses every 4, out_ready=0 for 40 edges -> rate_out=4 held, overrun=1 after 2nd window end; ready=1 -> out_valid=0, overrun=0.
//  5 CNT_W=2, pulses every 2 edges -> rate_out=3 (saturated); ISI_W=2, pulse gap 10 -> isi_out=3.
//  6 ena dropped at window cycle 9 -> no out_valid; ena back -> next full window reported correctly; window end coinciding with accept -> new value, out_valid stays 1.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train receiver: counts rising-edge spike events per fixed window (rate)
// and measures inter-spike interval; rate leaves over a valid/ready handshake.
module spike_rate_decoder #(
  parameter int WINDOW_LEN = 256,
  parameter int CNT_W      = 8,
  parameter int ISI_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic             out_ready,
  output logic [CNT_W-1:0] rate_out,
  output logic             out_valid,
  output logic             overrun,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid
);

  localparam int WIN_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state, state_nxt;
  logic             active;
  logic             spike_prev;
  logic             spike_evt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spike_cnt;
  logic [CNT_W-1:0] result;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] isi_next;
  logic             isi_seen;
  logic             win_last;
  logic             accept;
  logic             publish;
  logic             drop;

  function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] v,
                                                   input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  function automatic logic [ISI_W-1:0] sat_isi_inc(input logic [ISI_W-1:0] v);
    if (v != {ISI_W{1'b1}})
      return v + ISI_W'(1);
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The edge that samples ena=1 in IDLE is already window cycle 0, so
  // counting is active on that edge as well as throughout COUNT.
  always_comb begin
    state_nxt = state;
    active    = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          state_nxt = COUNT;
          active    = 1'b1;
        end
      end
      COUNT: begin
        if (ena) active    = 1'b1;
        else     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign spike_evt = spike_in & ~spike_prev;
  assign win_last  = (win_cnt == WIN_LAST);
  assign result    = sat_cnt_inc(spike_cnt, spike_evt);
  assign isi_next  = sat_isi_inc(isi_cnt);
  assign accept    = out_valid & out_ready;
  assign publish   = active & win_last & (~out_valid | out_ready);
  assign drop      = active & win_last & out_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_prev <= 1'b0;
      win_cnt    <= '0;
      spike_cnt  <= '0;
      isi_cnt    <= '0;
      isi_seen   <= 1'b0;
      isi_out    <= '0;
      isi_valid  <= 1'b0;
      rate_out   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      spike_prev <= spike_in;

      if (active) begin
        if (win_last) begin
          win_cnt   <= '0;
          spike_cnt <= '0;
        end else begin
          win_cnt   <= win_cnt + WIN_W'(1);
          spike_cnt <= result;
        end
        // The interval counter ignores window boundaries.
        if (spike_evt) begin
          isi_cnt  <= '0;
          isi_seen <= 1'b1;
        end else begin
          isi_cnt  <= isi_next;
        end
        isi_valid <= spike_evt & isi_seen;
        if (spike_evt && isi_seen)
          isi_out <= isi_next;
      end else begin
        win_cnt   <= '0;
        spike_cnt <= '0;
        isi_cnt   <= '0;
        isi_seen  <= 1'b0;
        isi_valid <= 1'b0;
      end

      // A publish coinciding with an accept replaces the value and keeps valid high.
      if (publish) begin
        rate_out  <= result;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      if (drop)        overrun <= 1'b1;
      else if (accept) overrun <= 1'b0;
    end
  end

endmodule
